ifu_fetch: RTL

Instruction fetch unit for the NPC core, the stage directly upstream of predecode/decode. It owns the fetch PC, issues one word-aligned read at a time to an instruction memory with variable latency, and hands each returned instruction with its PC to decode through a valid/ready handshake. Branch and jump redirects flush any in-flight or buffered instruction.

---
 rtl/ifu_fetch_if.sv | 44 ++++
 rtl/ifu_fetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: bundles the fetch unit's redirect, memory and decode-side
// signals. "master" is the fetch unit. "slave" is its environment, which
// covers the branch unit, the instruction memory and decode.
interface ifu_fetch_if #(
    parameter int DATA_WIDTH = 32
);
    // Redirect from branch/jump resolution
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;

    // Instruction memory request/response
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [DATA_WIDTH-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;

    // Decode-side instruction slot
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst_pc;
    logic [DATA_WIDTH-1:0] inst;

    // Debug view of the fetch FSM state
    logic [1:0]            state_dbg;

    modport master (
        input  redirect_valid, redirect_pc,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  inst_ready,
        output mem_req_valid, mem_req_addr,
        output inst_valid, inst_pc, inst,
        output state_dbg
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output inst_ready,
        input  mem_req_valid, mem_req_addr,
        input  inst_valid, inst_pc, inst,
        input  state_dbg
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit. It owns the fetch PC and keeps at most
// one word-aligned read outstanding to a variable-latency instruction memory.
// Each returned word goes into a one-entry slot, tagged with its PC, for
// decode. A redirect flushes the slot. It also discards any read that is
// still in flight.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer holds its valid high and its payload stable until
// the transfer. The exception is mem_req_*, which a redirect may withdraw.
// mem_rsp_valid carries no ready, and there is exactly one response per
// accepted request.
//
// Optional feature: define IFU_PERF_EN to add the fetch_cnt and wait_cnt
// performance counters and their ports.
module ifu_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
`ifdef IFU_PERF_EN
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       wait_cnt,
`endif
    ifu_fetch_if.master       bus
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,  // may issue a request
        ST_WAIT = 2'd1,  // a request is outstanding and its data is wanted
        ST_DROP = 2'd2   // a request is outstanding and its data is stale
    } state_e;

    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  slot_valid_q, slot_valid_d;
    logic [DATA_WIDTH-1:0] slot_pc_q, slot_pc_d;
    logic [DATA_WIDTH-1:0] slot_inst_q, slot_inst_d;

    logic                  slot_free;
    logic                  req_valid;
    logic                  req_fire;
    logic                  consume;
    logic                  rsp_load;

    // The slot can take new data if it is empty, or if decode drains it this
    // cycle. A pending redirect blocks the request, so no read can be
    // accepted for a PC that is about to be abandoned.
    assign slot_free = !slot_valid_q || bus.inst_ready;
    assign req_valid = !rst && (state_q == ST_REQ) && slot_free && !bus.redirect_valid;
    assign req_fire  = req_valid && bus.mem_req_ready;
    assign consume   = slot_valid_q && bus.inst_ready;
    assign rsp_load  = (state_q == ST_WAIT) && bus.mem_rsp_valid && !bus.redirect_valid;

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc_q;
    assign bus.inst_valid    = slot_valid_q;
    assign bus.inst_pc       = slot_pc_q;
    assign bus.inst          = slot_inst_q;
    assign bus.state_dbg     = state_q;

    // Next-state logic for the FSM, the PCs and the output slot. A redirect
    // is applied last so that it overrides the normal flow.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_inst_d  = slot_inst_q;

        if (consume) begin
            slot_valid_d = 1'b0;
        end

        case (state_q)
            ST_REQ: begin
                if (req_fire) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_d = ST_REQ;
                end
                // A load that coincides with a consume leaves the slot full
                // and holding the new data.
                if (rsp_load) begin
                    slot_valid_d = 1'b1;
                    slot_pc_d    = req_pc_q;
                    slot_inst_d  = bus.mem_rsp_data;
                end
            end
            ST_DROP: begin
                if (bus.mem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (bus.redirect_valid) begin
            fetch_pc_d   = bus.redirect_pc & ALIGN_MASK;
            slot_valid_d = 1'b0;
            if (state_q == ST_REQ) begin
                state_d = ST_REQ;
            end else if (bus.mem_rsp_valid) begin
                // The outstanding response lands this cycle and is discarded.
                state_d = ST_REQ;
            end else begin
                // One response is still owed and must be swallowed.
                state_d = ST_DROP;
            end
        end
    end

    // Register FSM, PCs and output slot; synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_REQ;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= '0;
            slot_valid_q <= 1'b0;
            slot_pc_q    <= '0;
            slot_inst_q  <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_inst_q  <= slot_inst_d;
        end
    end

`ifdef IFU_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    // fetch_cnt counts delivered instructions. wait_cnt counts cycles spent
    // with a read outstanding. Both wrap naturally.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, consume};
        wait_cnt_d  = wait_cnt_q + {31'd0, (state_q != ST_REQ)};
    end

    // Register the performance counters; synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign wait_cnt  = wait_cnt_q;
`else
    // Counters are compiled out; fetch behaviour is unchanged.
`endif

endmodule
